// File: rtl/esp_uart_rx.sv
// esp_uart_rx
// Receive front-end for the ESP serial link. Deserialises an asynchronous
// 8N1 stream into bytes. The bytes are buffered in a first-word-fall-through
// FIFO and leave on a valid/ready stream.
//
// Ports:
//   clk_clk       system clock, rising edge
//   reset_reset   synchronous active-high reset
//   esp_uart_rxd  asynchronous serial input, idles high
//   rx_data       FIFO head byte, meaningful while rx_valid
//   rx_valid      FIFO non-empty
//   rx_ready      consumer accepts head on rx_valid && rx_ready
//   rx_count      FIFO occupancy, 0..FIFO_DEPTH
//   framing_err   one-cycle pulse: stop bit sampled low
//   overflow      one-cycle pulse: good byte dropped, FIFO full
module esp_uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    localparam int DIV       = CLK_HZ / BAUD,
    localparam int HALF      = DIV / 2,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1,
    localparam int TW        = $clog2(DIV)
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          esp_uart_rxd,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [CW-1:0] rx_count,
    output logic          framing_err,
    output logic          overflow
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    // Both synchroniser stages reset high, so that a reset is never seen
    // as a start edge.
    logic sync1_q, rxs_q;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic          push;

    logic [FIFO_DEPTH-1:0][7:0] mem_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop, full, wr_en;

    // The timer counts cycles spent in the current state. The timer starts
    // at 0 on entry. The sample point is the last count of the interval.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (tmr_q == TW'(HALF - 1)) begin
                    tmr_d = '0;
                    bit_d = '0;
                    // High at mid-start means a glitch. Drop it silently.
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tmr_q == TW'(DIV - 1)) begin
                    tmr_d   = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (tmr_q == TW'(DIV - 1)) begin
                    tmr_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off during a break so that the low line is not
                // taken as a new start bit.
                tmr_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The FIFO is full with a pop in the same cycle. This frees a slot,
    // so the incoming byte is still accepted.
    always_comb begin
        pop      = (cnt_q != '0) && rx_ready;
        full     = (cnt_q == CW'(FIFO_DEPTH));
        wr_en    = push && (!full || pop);
        ovf_d    = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            state_q  <= IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= esp_uart_rxd;
            rxs_q    <= sync1_q;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // The storage array has no reset. Its contents matter only behind a
    // valid count.
    always_ff @(posedge clk_clk) begin
        if (wr_en && !reset_reset) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (cnt_q != '0);
    assign rx_count    = cnt_q;
    assign framing_err = ferr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_esp_uart_rx.sv
// Testbench for esp_uart_rx. It runs at DIV=10, HALF=5, FIFO_DEPTH=4.
// Expected bytes are queued when each frame is driven. They are compared
// when the bytes are popped from the DUT.
module tb_esp_uart_rx;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          reset_reset;
    logic          esp_uart_rxd;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] rx_count;
    logic          framing_err;
    logic          overflow;

    always #5 clk = ~clk;

    esp_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .esp_uart_rxd(esp_uart_rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_count    (rx_count),
        .framing_err (framing_err),
        .overflow    (overflow)
    );

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;

    logic [7:0] sb[$];
    logic       hist_v[0:255];
    logic       hist_o[0:255];

    // Count the cycles in which each flag is high. A delta of exactly 1
    // therefore means a single-cycle pulse.
    always @(negedge clk) begin
        if (framing_err) ferr_cnt++;
        if (overflow)    ovf_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        int         stop_len;
        logic       stop_val;
        int         idle;
        bit         drain;
        int         exp_cnt;
        int         exp_ovf;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int t, input logic sv);
        if (t < 10)      return 1'b0;
        else if (t < 90) return d[t/10-1];
        else             return sv;
    endfunction

    // Offset t is the tick index from the pin falling edge. The history
    // index n is the number of edges since the fall.
    task automatic send_frame(input logic [7:0] d, input int stop_len, input logic sv, input int idle);
        for (int t = 0; t < 90 + stop_len + idle; t++) begin
            esp_uart_rxd = (t < 90 + stop_len) ? line_bit(d, t, sv) : 1'b1;
            tick;
            if (t + 1 < 256) begin
                hist_v[t+1] = rx_valid;
                hist_o[t+1] = overflow;
            end
        end
        esp_uart_rxd = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = sb.pop_front();
        chk({name, " valid"}, {31'd0, rx_valid}, 32'd1);
        chk({name, " data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
    endtask

    initial begin
        int f0, o0;

        tbl[0] = '{8'h00, 10, 1'b1, 0,  1'b0, 1, 0, 0};
        tbl[1] = '{8'hFF, 10, 1'b1, 0,  1'b0, 2, 0, 0};
        tbl[2] = '{8'h3C, 10, 1'b1, 0,  1'b0, 3, 0, 0};
        tbl[3] = '{8'h81, 10, 1'b1, 0,  1'b0, 4, 0, 0};
        tbl[4] = '{8'h7E, 10, 1'b1, 10, 1'b0, 4, 1, 0};
        tbl[5] = '{8'h55, 30, 1'b0, 10, 1'b1, 0, 0, 1};
        tbl[6] = '{8'h12, 10, 1'b1, 10, 1'b0, 1, 0, 0};

        // Reset with the line idle.
        reset_reset  = 1'b1;
        esp_uart_rxd = 1'b1;
        rx_ready     = 1'b0;
        repeat (5) tick;
        reset_reset = 1'b0;
        repeat (50) tick;
        chk("reset valid", {31'd0, rx_valid}, 32'd0);
        chk("reset count", {29'd0, rx_count}, 32'd0);
        chk("reset ferr",  {31'd0, framing_err}, 32'd0);
        chk("reset ovf",   {31'd0, overflow}, 32'd0);
        chk("reset pulses", ferr_cnt + ovf_cnt, 32'd0);

        // Single byte: rx_valid first appears 98 edges after the pin falls.
        sb.push_back(8'hA5);
        send_frame(8'hA5, 10, 1'b1, 5);
        chk("A5 lat-1", {31'd0, hist_v[97]}, 32'd0);
        chk("A5 lat",   {31'd0, hist_v[98]}, 32'd1);
        chk("A5 count", {29'd0, rx_count}, 32'd1);
        pop_check("A5");
        chk("A5 empty", {31'd0, rx_valid}, 32'd0);

        // Table: back-to-back fill, overflow, framing error, recovery.
        foreach (tbl[i]) begin
            if (tbl[i].drain) begin
                while (sb.size() > 0) pop_check("drain");
                chk("drained count", {29'd0, rx_count}, 32'd0);
            end
            f0 = ferr_cnt;
            o0 = ovf_cnt;
            if (tbl[i].stop_val && tbl[i].exp_ovf == 0) sb.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop_len, tbl[i].stop_val, tbl[i].idle);
            chk($sformatf("vec%0d count", i), {29'd0, rx_count}, tbl[i].exp_cnt);
            chk($sformatf("vec%0d ovf", i), ovf_cnt - o0, tbl[i].exp_ovf);
            chk($sformatf("vec%0d ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
            if (tbl[i].exp_ovf != 0) begin
                chk($sformatf("vec%0d ovf-at-stop", i), {31'd0, hist_o[98]}, 32'd1);
                chk($sformatf("vec%0d ovf-early", i), {31'd0, hist_o[97]}, 32'd0);
            end
        end
        pop_check("12");
        chk("12 empty", {29'd0, rx_count}, 32'd0);

        // Short glitch on an idle line: expect no push and no flags. The
        // following frame must keep the exact latency.
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        esp_uart_rxd = 1'b0;
        repeat (3) tick;
        esp_uart_rxd = 1'b1;
        repeat (20) tick;
        chk("glitch count", {29'd0, rx_count}, 32'd0);
        chk("glitch flags", (ferr_cnt - f0) + (ovf_cnt - o0), 32'd0);
        sb.push_back(8'h33);
        send_frame(8'h33, 10, 1'b1, 5);
        chk("33 lat-1", {31'd0, hist_v[97]}, 32'd0);
        chk("33 lat",   {31'd0, hist_v[98]}, 32'd1);
        pop_check("33");

        // Reset in the middle of bit 4 while two bytes are buffered.
        sb.push_back(8'h11);
        send_frame(8'h11, 10, 1'b1, 0);
        sb.push_back(8'h22);
        send_frame(8'h22, 10, 1'b1, 0);
        chk("pre-reset count", {29'd0, rx_count}, 32'd2);
        for (int t = 0; t < 55; t++) begin
            esp_uart_rxd = line_bit(8'h5A, t, 1'b1);
            tick;
        end
        esp_uart_rxd = 1'b1;
        reset_reset  = 1'b1;
        tick;
        reset_reset  = 1'b0;
        chk("midreset count", {29'd0, rx_count}, 32'd0);
        chk("midreset valid", {31'd0, rx_valid}, 32'd0);
        sb.delete();
        repeat (20) tick;
        sb.push_back(8'h99);
        send_frame(8'h99, 10, 1'b1, 5);
        chk("99 count", {29'd0, rx_count}, 32'd1);
        pop_check("99");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
